// File: rtl/tail_light_sequencer.sv
// Front-end for the tail-light engine: synchronises the switches, arbitrates
// left/right/hazard and emits one step strobe per slow tick.
module tail_light_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int DIV_W    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       hazard_sw,
  output logic       step,
  output logic       req_left,
  output logic       req_right,
  output logic [1:0] mode,
  output logic       busy,
  output logic [7:0] seq_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [0:0]       state;
  logic [1:0]       phase;
  logic [1:0]       req_mode;

  // Bit order {hazard, right, left} in both synchroniser stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= {hazard_sw, right_sw, left_sw};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_MAX);

  // Left+right together is treated as a hazard request.
  always_comb begin
    req_mode = 2'b00;
    if (sync2[2] || (sync2[0] && sync2[1])) begin
      req_mode = 2'b11;
    end else if (sync2[0]) begin
      req_mode = 2'b01;
    end else if (sync2[1]) begin
      req_mode = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= 2'd0;
      step      <= 1'b0;
      req_left  <= 1'b0;
      req_right <= 1'b0;
      mode      <= 2'b00;
      busy      <= 1'b0;
      seq_count <= 8'd0;
    end else begin
      step      <= 1'b0;
      req_left  <= 1'b0;
      req_right <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (req_mode != 2'b00) begin
              step      <= 1'b1;
              req_left  <= req_mode[0];
              req_right <= req_mode[1];
              mode      <= req_mode;
              phase     <= 2'd1;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
          default: begin
            step <= 1'b1;
            // Switches are ignored here so a started sequence always completes.
            if (phase == 2'd3) begin
              phase     <= 2'd0;
              busy      <= 1'b0;
              mode      <= 2'b00;
              seq_count <= seq_count + 8'd1;
              state     <= IDLE;
            end else begin
              phase <= phase + 2'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
